// File: rtl/dbus_mem_responder_pkg.sv
// Shared types for the data-bus load/store protocol: access sizes, responder
// FSM states, request payload and the lane-mask helper used by both ends.
package dbus_mem_responder_pkg;

    localparam int unsigned DATA_W = 64;
    localparam int unsigned ADDR_W = 64;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned SIZE_W = 3;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [SIZE_W-1:0] {
        MSize_8bits  = 3'd1,
        MSize_16bits = 3'd2,
        MSize_32bits = 3'd3,
        MSize_64bits = 3'd4
    } MemSizeType;

    typedef enum logic [1:0] {
        DR_IDLE,
        DR_WAIT,
        DR_RESP
    } dr_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [SIZE_W-1:0] size;
        logic [STRB_W-1:0] strobe;
        logic [DATA_W-1:0] data;
    } dreq_t;

    // Strobe pattern a legal access of this size at this byte offset must use.
    function automatic logic [STRB_W-1:0] size_lane_mask(input logic [SIZE_W-1:0] size,
                                                         input logic [2:0]        offset);
        logic [STRB_W-1:0] mask;
        case (size)
            MSize_8bits:  mask = 8'h01 << offset;
            MSize_16bits: mask = 8'h03 << offset;
            MSize_32bits: mask = 8'h0F << offset;
            MSize_64bits: mask = 8'hFF;
            default:      mask = 8'h00;
        endcase
        return mask;
    endfunction

    // Natural alignment of the byte offset for the access size; unknown sizes fail.
    function automatic logic size_aligned(input logic [SIZE_W-1:0] size,
                                          input logic [2:0]        offset);
        logic ok;
        case (size)
            MSize_8bits:  ok = 1'b1;
            MSize_16bits: ok = (offset[0] == 1'b0);
            MSize_32bits: ok = (offset[1:0] == 2'b00);
            MSize_64bits: ok = (offset == 3'b000);
            default:      ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dbus_sram_bank.sv
// DEPTH x 64-bit word RAM with per-byte write enables; the read port is
// asynchronous so it always shows the value from before this cycle's write.
module dbus_sram_bank
    import dbus_mem_responder_pkg::*;
#(
    parameter int unsigned DEPTH = 1024
) (
    input  logic                     clk,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [STRB_W-1:0]        wr_be,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        rdata_c
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < int'(STRB_W); b++) begin
            if (wr_be[b]) begin
                mem_q[idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    assign rdata_c = mem_q[idx];

endmodule

// File: rtl/dbus_mem_responder.sv
// Fixed-latency data-bus responder: one outstanding request, registered
// addr_ok/data_ok handshake, sticky misalignment and out-of-range flags.
module dbus_mem_responder
    import dbus_mem_responder_pkg::*;
#(
    parameter int unsigned       DEPTH   = 1024,
    parameter logic [ADDR_W-1:0] BASE    = 64'h8000_0000,
    parameter int unsigned       LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dreq_valid,
    input  logic [ADDR_W-1:0] dreq_addr,
    input  logic [SIZE_W-1:0] dreq_size,
    input  logic [STRB_W-1:0] dreq_strobe,
    input  logic [DATA_W-1:0] dreq_data,
    output logic              dresp_addr_ok,
    output logic              dresp_data_ok,
    output logic [DATA_W-1:0] dresp_data,
    output logic              misalign_err,
    output logic              oob_err
);

    localparam int unsigned       IDX_W    = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] SPAN     = ADDR_W'(DEPTH) << 3;
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(LATENCY - 1);

    dr_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    dreq_t             req_q, req_d;
    logic              addr_ok_q, addr_ok_d;
    logic              data_ok_q, data_ok_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              misalign_q, misalign_d;
    logic              oob_q, oob_d;

    dreq_t             in_c;
    dreq_t             cur_c;
    logic [ADDR_W-1:0] off_c;
    logic              oob_c;
    logic              bad_c;
    logic [IDX_W-1:0]  idx_c;
    logic              we_c;
    logic [STRB_W-1:0] wr_be_c;
    logic [DATA_W-1:0] rdata_c;

    function automatic logic req_legal(input logic [SIZE_W-1:0] size,
                                       input logic [2:0]        offset,
                                       input logic [STRB_W-1:0] strobe);
        return size_aligned(size, offset) &&
               ((strobe == '0) || (strobe == size_lane_mask(size, offset)));
    endfunction

    assign in_c = '{addr: dreq_addr, size: dreq_size, strobe: dreq_strobe, data: dreq_data};

    // In IDLE the live request is judged (needed for LATENCY==1); afterwards the latched one.
    always_comb begin
        cur_c = (state_q == DR_IDLE) ? in_c : req_q;
        off_c = cur_c.addr - BASE;
        oob_c = (off_c >= SPAN);
        bad_c = !req_legal(cur_c.size, cur_c.addr[2:0], cur_c.strobe);
        idx_c = off_c[IDX_W+2:3];
    end

    // The write lands on the RESP edge; a reset on that edge cancels it.
    always_comb begin
        we_c    = (state_q == DR_RESP) && !reset && !bad_c && !oob_c;
        wr_be_c = we_c ? cur_c.strobe : '0;
    end

    dbus_sram_bank #(
        .DEPTH (DEPTH)
    ) u_bank (
        .clk     (clk),
        .idx     (idx_c),
        .wr_be   (wr_be_c),
        .wr_data (cur_c.data),
        .rdata_c (rdata_c)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        misalign_d = misalign_q;
        oob_d      = oob_q;

        case (state_q)
            DR_IDLE: begin
                if (dreq_valid) begin
                    req_d      = in_c;
                    cnt_d      = CNT_INIT;
                    misalign_d = misalign_q | bad_c;
                    oob_d      = oob_q | oob_c;
                    state_d    = (LATENCY == 1) ? DR_RESP : DR_WAIT;
                end
            end
            DR_WAIT: begin
                if (!dreq_valid) begin
                    cnt_d   = '0;
                    state_d = DR_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DR_RESP;
                    end
                end
            end
            DR_RESP: begin
                state_d = DR_IDLE;
            end
            default: begin
                state_d = DR_IDLE;
            end
        endcase

        // Handshake is registered, so it is raised on the edge entering RESP.
        addr_ok_d = (state_d == DR_RESP);
        data_ok_d = (state_d == DR_RESP);
        data_d    = ((state_d == DR_RESP) && !bad_c && !oob_c) ? rdata_c : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= DR_IDLE;
            cnt_q      <= '0;
            req_q      <= '0;
            addr_ok_q  <= 1'b0;
            data_ok_q  <= 1'b0;
            data_q     <= '0;
            misalign_q <= 1'b0;
            oob_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            addr_ok_q  <= addr_ok_d;
            data_ok_q  <= data_ok_d;
            data_q     <= data_d;
            misalign_q <= misalign_d;
            oob_q      <= oob_d;
        end
    end

    assign dresp_addr_ok = addr_ok_q;
    assign dresp_data_ok = data_ok_q;
    assign dresp_data    = data_q;
    assign misalign_err  = misalign_q;
    assign oob_err       = oob_q;

endmodule

// File: tb/tb_dbus_mem_responder.sv
// Scoreboard bench: two responders (latency 2 and 3) share a clock; requests
// push their expected response, the monitor pops and compares on data_ok.
module tb_dbus_mem_responder;
    import dbus_mem_responder_pkg::*;

    typedef struct {
        int          u;
        logic [63:0] data;
        bit          chk;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset         [2];
    logic        dreq_valid    [2];
    logic [63:0] dreq_addr     [2];
    logic [2:0]  dreq_size     [2];
    logic [7:0]  dreq_strobe   [2];
    logic [63:0] dreq_data     [2];
    logic        dresp_addr_ok [2];
    logic        dresp_data_ok [2];
    logic [63:0] dresp_data    [2];
    logic        misalign_err  [2];
    logic        oob_err       [2];

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc     = 0;
    int   n_vec   = 0;
    int   n_err   = 0;
    int   ok_seen = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dbus_mem_responder #(.DEPTH(1024), .BASE(64'h8000_0000), .LATENCY(2)) u_dut0 (
        .clk(clk), .reset(reset[0]), .dreq_valid(dreq_valid[0]), .dreq_addr(dreq_addr[0]),
        .dreq_size(dreq_size[0]), .dreq_strobe(dreq_strobe[0]), .dreq_data(dreq_data[0]),
        .dresp_addr_ok(dresp_addr_ok[0]), .dresp_data_ok(dresp_data_ok[0]),
        .dresp_data(dresp_data[0]), .misalign_err(misalign_err[0]), .oob_err(oob_err[0]));

    dbus_mem_responder #(.DEPTH(1024), .BASE(64'h8000_0000), .LATENCY(3)) u_dut1 (
        .clk(clk), .reset(reset[1]), .dreq_valid(dreq_valid[1]), .dreq_addr(dreq_addr[1]),
        .dreq_size(dreq_size[1]), .dreq_strobe(dreq_strobe[1]), .dreq_data(dreq_data[1]),
        .dresp_addr_ok(dresp_addr_ok[1]), .dresp_data_ok(dresp_data_ok[1]),
        .dresp_data(dresp_data[1]), .misalign_err(misalign_err[1]), .oob_err(oob_err[1]));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // Response monitor: every data_ok must match the oldest outstanding expectation.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            if (dresp_data_ok[u] === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_resp", 64'(u), 64'hFFFF);
                end else begin
                    mon_e = sb_q.pop_front();
                    check_eq("resp_unit", 64'(u), 64'(mon_e.u));
                    check_eq("resp_addr_ok", 64'(dresp_addr_ok[u]), 64'd1);
                    check_eq("resp_latency", 64'(cyc - mon_e.cyc), (u == 0) ? 64'd2 : 64'd3);
                    if (mon_e.chk) check_eq("resp_data", dresp_data[u], mon_e.data);
                end
            end
        end
    end

    task automatic drive(input int u, input logic [63:0] addr, input logic [2:0] size,
                         input logic [7:0] strb, input logic [63:0] wd);
        dreq_valid[u]  = 1'b1;
        dreq_addr[u]   = addr;
        dreq_size[u]   = size;
        dreq_strobe[u] = strb;
        dreq_data[u]   = wd;
    endtask

    // One full transaction; exp is the required dresp_data when chk is set.
    task automatic req(input int u, input logic [63:0] addr, input logic [2:0] size,
                       input logic [7:0] strb, input logic [63:0] wd,
                       input logic [63:0] exp, input bit chk);
        bit seen = 1'b0;
        @(posedge clk); #1;
        sb_q.push_back('{u: u, data: exp, chk: chk, cyc: cyc});
        drive(u, addr, size, strb, wd);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (dresp_data_ok[u] === 1'b1) seen = 1'b1;
        end
        if (!seen) check_eq("resp_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        dreq_valid[u] = 1'b0;
    endtask

    localparam logic [63:0] W0   = 64'h8000_0010;
    localparam logic [63:0] WEND = 64'h8000_1FF8;

    initial begin
        for (int u = 0; u < 2; u++) begin
            reset[u] = 1'b1;
            drive(u, 64'h0, 3'd0, 8'h00, 64'h0);
            dreq_valid[u] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            check_eq("rst_addr_ok", 64'(dresp_addr_ok[u]), 64'd0);
            check_eq("rst_data_ok", 64'(dresp_data_ok[u]), 64'd0);
            check_eq("rst_data", dresp_data[u], 64'd0);
            check_eq("rst_misalign", 64'(misalign_err[u]), 64'd0);
            check_eq("rst_oob", 64'(oob_err[u]), 64'd0);
            reset[u] = 1'b0;
        end

        // Doubleword write/read, then partial-lane writes of each size.
        req(0, W0, 3'd4, 8'hFF, 64'h1122_3344_5566_7788, 64'h0, 1'b0);
        req(0, W0, 3'd4, 8'h00, 64'h0, 64'h1122_3344_5566_7788, 1'b1);
        check_eq("misalign_clean", 64'(misalign_err[0]), 64'd0);
        req(0, W0 + 3, 3'd1, 8'h08, 64'h0000_0000_AA00_0000, 64'h1122_3344_5566_7788, 1'b1);
        req(0, W0, 3'd4, 8'h00, 64'h0, 64'h1122_3344_AA66_7788, 1'b1);
        req(0, W0 + 6, 3'd2, 8'hC0, 64'hCAFE_0000_0000_0000, 64'h1122_3344_AA66_7788, 1'b1);
        req(0, W0, 3'd4, 8'h00, 64'h0, 64'hCAFE_3344_AA66_7788, 1'b1);
        req(0, W0 + 4, 3'd3, 8'hF0, 64'hDEAD_BEEF_0000_0000, 64'hCAFE_3344_AA66_7788, 1'b1);
        req(0, W0, 3'd4, 8'h00, 64'h0, 64'hDEAD_BEEF_AA66_7788, 1'b1);

        // Illegal requests answer zero and never write.
        req(0, W0 + 2, 3'd3, 8'h00, 64'h0, 64'h0, 1'b1);
        check_eq("misalign_set", 64'(misalign_err[0]), 64'd1);
        req(0, W0 + 2, 3'd3, 8'h3C, 64'h0000_1234_5678_0000, 64'h0, 1'b1);
        req(0, W0 + 1, 3'd1, 8'h04, 64'h0000_0000_0055_0000, 64'h0, 1'b1);
        req(0, W0, 3'd0, 8'h00, 64'h0, 64'h0, 1'b1);
        req(0, W0, 3'd4, 8'h00, 64'h0, 64'hDEAD_BEEF_AA66_7788, 1'b1);
        check_eq("misalign_sticky", 64'(misalign_err[0]), 64'd1);
        check_eq("oob_clean", 64'(oob_err[0]), 64'd0);

        // Range edges: last word works, just outside on either side does not.
        req(0, WEND, 3'd4, 8'hFF, 64'h0123_4567_89AB_CDEF, 64'h0, 1'b0);
        req(0, WEND, 3'd4, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b1);
        req(0, 64'h7FFF_FFF8, 3'd4, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1);
        check_eq("oob_set", 64'(oob_err[0]), 64'd1);
        req(0, 64'h8000_2000, 3'd4, 8'h00, 64'h0, 64'h0, 1'b1);
        req(0, WEND, 3'd4, 8'h00, 64'h0, 64'h0123_4567_89AB_CDEF, 1'b1);
        check_eq("oob_sticky", 64'(oob_err[0]), 64'd1);

        // Reset during the RESP cycle of a store cancels it.
        @(posedge clk); #1;
        sb_q.push_back('{u: 0, data: 64'hDEAD_BEEF_AA66_7788, chk: 1'b1, cyc: cyc});
        drive(0, W0, 3'd4, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset[0] = 1'b1;
        @(posedge clk); #1;
        check_eq("rstresp_addr_ok", 64'(dresp_addr_ok[0]), 64'd0);
        check_eq("rstresp_data_ok", 64'(dresp_data_ok[0]), 64'd0);
        check_eq("rstresp_data", dresp_data[0], 64'd0);
        check_eq("rstresp_state", 64'(u_dut0.state_q), 64'(DR_IDLE));
        check_eq("rstresp_misalign", 64'(misalign_err[0]), 64'd0);
        check_eq("rstresp_oob", 64'(oob_err[0]), 64'd0);
        reset[0]      = 1'b0;
        dreq_valid[0] = 1'b0;
        req(0, W0, 3'd4, 8'h00, 64'h0, 64'hDEAD_BEEF_AA66_7788, 1'b1);

        // Latency-3 unit: abandon a store in its second WAIT cycle.
        req(1, 64'h8000_0040, 3'd4, 8'hFF, 64'hA5A5_A5A5_A5A5_A5A5, 64'h0, 1'b0);
        req(1, 64'h8000_0040, 3'd4, 8'h00, 64'h0, 64'hA5A5_A5A5_A5A5_A5A5, 1'b1);
        @(posedge clk); #1;
        drive(1, 64'h8000_0040, 3'd4, 8'hFF, 64'h5A5A_5A5A_5A5A_5A5A);
        @(posedge clk); #1;
        @(posedge clk); #1;
        dreq_valid[1] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (dresp_data_ok[1] === 1'b1) ok_seen++;
        end
        check_eq("abort_no_resp", 64'(ok_seen), 64'd0);
        req(1, 64'h8000_0040, 3'd4, 8'h00, 64'h0, 64'hA5A5_A5A5_A5A5_A5A5, 1'b1);
        req(1, 64'h8000_0045, 3'd1, 8'h20, 64'h0000_7700_0000_0000, 64'hA5A5_A5A5_A5A5_A5A5, 1'b1);
        req(1, 64'h8000_0040, 3'd4, 8'h00, 64'h0, 64'hA5A5_77A5_A5A5_A5A5, 1'b1);
        check_eq("lat3_misalign", 64'(misalign_err[1]), 64'd0);

        repeat (4) @(posedge clk);
        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dbus_mem_responder.md
Name: dbus_mem_responder

Overview:
- Responder end of the data-bus load/store protocol driven by the memory stage. The memory stage acts on the MemRead, MemWrite and MemSize control fields.
- Holds a DEPTH x 64-bit word SRAM. Accepts one request at a time, waits a programmable latency, then answers with the addr_ok/data_ok handshake.
- Used as the data memory behind the pipeline in simulation and on FPGA. Also usable as a fixed-latency memory model for stage-level benches.

Parameters:
- DEPTH, 1024, number of 64-bit words; power of two.
- BASE, 64'h8000_0000, byte address of word 0; DEPTH*8-aligned.
- LATENCY, 2, cycles from request acceptance to response; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- dreq_valid  in  1  request present; requester holds it and all dreq_* fields stable until dresp_data_ok
- dreq_addr  in  64  byte address
- dreq_size  in  3  MemSizeType encoding: MSize_8bits=1, MSize_16bits=2, MSize_32bits=3, MSize_64bits=4
- dreq_strobe  in  8  byte-lane write enables; all zero = read
- dreq_data  in  64  write data, already lane-aligned
- dresp_addr_ok  out  1  request accepted
- dresp_data_ok  out  1  response valid
- dresp_data  out  64  whole aligned doubleword; requester does lane extraction and extension per WBType
- misalign_err  out  1  sticky error: misaligned or illegal request
- oob_err  out  1  sticky error: address outside [BASE, BASE+DEPTH*8)

Behaviour:
- Decision: already decided, one clock; reset is synchronous and active-high (clk, reset).
- Reset values: all outputs 0, FSM = IDLE, counter = 0. SRAM contents are not cleared by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE, dreq_valid=1:
  - Latch addr, size, strobe and data.
  - Compute word index = (addr - BASE) >> 3.
  - Counter = LATENCY-1.
  - Go to RESP if LATENCY==1, else go to WAIT.
- WAIT: decrement counter each cycle; when counter==1, go to RESP.
- Latency: the response appears exactly LATENCY cycles after the accepting cycle.
- RESP, single cycle:
  - dresp_addr_ok = dresp_data_ok = 1; outputs are registered, so they are high only in RESP.
  - dresp_data = word value before any write this cycle.
  - For a legal in-range write, write dreq_data into the strobed byte lanes.
  - Next state IDLE. The requester drops dreq_valid the next cycle; a new request is accepted in the first IDLE cycle with valid=1, so back-to-back requests are LATENCY+1 cycles apart.
- Legality check, done at acceptance:
  - Size 1: any offset; strobe, if nonzero, must be 1<<addr[2:0].
  - Size 2: addr[0]==0; strobe nonzero must be 2'b11<<addr[2:0].
  - Size 3: addr[1:0]==0; strobe nonzero must be 4'hF<<addr[2:0].
  - Size 4: addr[2:0]==0; strobe nonzero must be 8'hFF.
  - Size 0 or 5..7: illegal.
- Illegal request: set misalign_err, respond normally with dresp_data = 0, perform no write.
- Out-of-range address: set oob_err, respond with dresp_data = 0, perform no write. If both errors apply, set both flags.
- Sticky errors: cleared only by reset.
- Abort: dreq_valid=0 while in WAIT means the request is abandoned. Go to IDLE with no write and no response.
- Reset in WAIT or RESP: back to IDLE with no write that cycle and outputs 0.
- Reads with strobe=0 never modify the SRAM.

Decomposition:
- Shared package holds MemSizeType, reused from the pipeline package, plus a new typedef enum for the FSM states (DR_IDLE, DR_WAIT, DR_RESP).
- Shared package also holds a function size_lane_mask(size, offset) returning the 8-bit legal strobe. The memory-stage requester uses the same function to generate strobes.
- One natural sub-module: dbus_sram_bank, a DEPTH x 64 RAM with per-byte write enable and an asynchronous read of the pre-write value.

Test Plan:
- Write then read a doubleword: sd to 0x8000_0010 with data 0x1122334455667788, strobe FF, then ld of the same address → each data_ok arrives 2 cycles after acceptance; the read returns 0x1122334455667788; misalign_err=0.
- Byte write: after the test above, sb at 0x8000_0013 with data 0xAA<<24 and strobe 0x08 → a later ld returns 0x11223344AA667788.
- Misaligned access: lw at 0x8000_0012 (size 3) → response with data 0; misalign_err=1 and stays 1; the word at 0x...10 is unchanged.
- Out of range: sd at 0x7FFF_FFF8 → oob_err=1, no write, data 0. A read at BASE+DEPTH*8-8 still works.
- Abort: with LATENCY=3, valid drops in the second WAIT cycle of an sd → no data_ok; a following ld of that address returns the old value.
- Reset in RESP: reset asserted in the RESP cycle of an sd → dresp_* are 0 that cycle, the write is suppressed, and the FSM is in IDLE.
